// File: rtl/neuron_mac_bank.sv
// rtl/neuron_mac_bank.sv - per-unit weight/activation buffer with serial MAC and result stream
//
// Captures {weight, activation} words into NUM_UNITS x WORDS local registers and,
// on a rising edge of sum_trigger, computes one fixed-point dot product per unit.
// The sums are streamed out one unit at a time over a valid/ready handshake.
//
// Build option: NEURON_MAC_SAT_EN - saturate the scaled sum to the signed DATA_W
// range instead of wrapping.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-low reset
//   ram_data        {weight, activation}, both signed, valid with write
//   write           capture strobe, honoured only while idle
//   unit_sel        destination unit of a capture
//   unit_address    word index within the unit
//   sum_trigger     start request, rising edge only
//   result_ready    consumer accepts the presented result
//   result_valid    a result is presented
//   result_data     scaled unit sum
//   result_unit     unit index of result_data
//   busy            engine is not idle
//   done            one-cycle pulse after the last result is accepted
//   overrun         sticky: write or start seen while busy
module neuron_mac_bank #(
    parameter int DATA_W    = 16,
    parameter int NUM_UNITS = 4,
    parameter int WORDS     = 4,
    parameter int ACC_W     = 40,
    parameter int FRAC      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*DATA_W-1:0]   ram_data,
    input  logic                  write,
    input  logic [2:0]            unit_sel,
    input  logic [2:0]            unit_address,
    input  logic                  sum_trigger,
    input  logic                  result_ready,
    output logic                  result_valid,
    output logic [DATA_W-1:0]     result_data,
    output logic [2:0]            result_unit,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] NU = 4'(NUM_UNITS);
    localparam logic [3:0] NW = 4'(WORDS);
    localparam logic [2:0] LAST_U = 3'(NUM_UNITS - 1);
    localparam logic [2:0] LAST_W = 3'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_HOLD} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [2*DATA_W-1:0]        r_mem [NUM_UNITS][WORDS];
    logic                       r_trig;
    logic [2:0]                 r_u;
    logic [2:0]                 r_w;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_start;
    logic                       w_accept;
    logic                       w_in_range;
    logic [2*DATA_W-1:0]        w_word;
    logic signed [DATA_W-1:0]   w_weight;
    logic signed [DATA_W-1:0]   w_act;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]          w_scaled;

    assign busy       = (r_state != S_IDLE);
    assign w_start    = sum_trigger & ~r_trig;
    assign w_accept   = (r_state == S_HOLD) & result_valid & result_ready;
    assign w_in_range = ({1'b0, unit_sel} < NU) && ({1'b0, unit_address} < NW);

    assign w_word   = r_mem[r_u[UW-1:0]][r_w[WW-1:0]];
    assign w_weight = w_word[2*DATA_W-1:DATA_W];
    assign w_act    = w_word[DATA_W-1:0];
    assign w_prod   = w_weight * w_act;

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] w_shifted;
    assign w_shifted = r_acc >>> FRAC;
    always_comb begin
        w_scaled = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_scaled = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_scaled = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    // Low DATA_W bits of acc >>> FRAC are exactly this slice; the sign fill is discarded.
    assign w_scaled = r_acc[FRAC +: DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_MAC;
            S_MAC:  if (r_w == LAST_W) w_next = S_EMIT;
            S_EMIT: w_next = S_HOLD;
            S_HOLD: if (w_accept) w_next = (r_u == LAST_U) ? S_IDLE : S_MAC;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                for (int j = 0; j < WORDS; j++) begin
                    r_mem[i][j] <= '0;
                end
            end
            r_trig       <= 1'b0;
            r_u          <= '0;
            r_w          <= '0;
            r_acc        <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_unit  <= '0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            r_trig <= sum_trigger;
            done   <= 1'b0;

            if (write) begin
                if (busy) begin
                    overrun <= 1'b1;
                end else if (w_in_range) begin
                    r_mem[unit_sel[UW-1:0]][unit_address[WW-1:0]] <= ram_data;
                end
            end
            if (w_start && busy) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_u   <= '0;
                        r_w   <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
                    r_w   <= r_w + 3'd1;
                end
                S_EMIT: begin
                    result_data  <= w_scaled;
                    result_unit  <= r_u;
                    result_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_accept) begin
                        result_valid <= 1'b0;
                        if (r_u == LAST_U) begin
                            done <= 1'b1;
                        end else begin
                            r_u   <= r_u + 3'd1;
                            r_w   <= '0;
                            r_acc <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_bank.sv
// tb/tb_neuron_mac_bank.sv - directed scoreboard bench for neuron_mac_bank
module tb_neuron_mac_bank;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ram_data = '0;
    logic        write = 1'b0;
    logic [2:0]  unit_sel = '0;
    logic [2:0]  unit_address = '0;
    logic        sum_trigger = 1'b0;
    logic        result_ready = 1'b0;
    logic        result_valid;
    logic [15:0] result_data;
    logic [2:0]  result_unit;
    logic        busy;
    logic        done;
    logic        overrun;

    int          vectors = 0;
    int          errs = 0;
    logic [18:0] sb[$];

`ifdef NEURON_MAC_SAT_EN
    localparam logic [15:0] BIG_EXP = 16'h7FFF;
`else
    localparam logic [15:0] BIG_EXP = 16'hFC00;
`endif

    neuron_mac_bank dut (
        .clk          (clk),
        .reset        (reset),
        .ram_data     (ram_data),
        .write        (write),
        .unit_sel     (unit_sel),
        .unit_address (unit_address),
        .sum_trigger  (sum_trigger),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_unit  (result_unit),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] u, input logic [2:0] a, input logic [15:0] w, input logic [15:0] x);
        @(negedge clk);
        write = 1'b1; unit_sel = u; unit_address = a; ram_data = {w, x};
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic push4(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        sb.push_back({3'd0, d0});
        sb.push_back({3'd1, d1});
        sb.push_back({3'd2, d2});
        sb.push_back({3'd3, d3});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   32'(result_valid), 32'h0);
        check({tag, "_data"},    32'(result_data),  32'h0);
        check({tag, "_unit"},    32'(result_unit),  32'h0);
        check({tag, "_busy"},    32'(busy),         32'h0);
        check({tag, "_done"},    32'(done),         32'h0);
        check({tag, "_overrun"}, 32'(overrun),      32'h0);
    endtask

    // Caller raises sum_trigger (and optionally a write) at a negedge, then calls this.
    task automatic collect(input int stall, input bit inject);
        int          cyc = 0;
        int          last_acc = 0;
        int          stall_left = stall;
        int          n_done = 0;
        logic        prev_v = 1'b0;
        logic        held = 1'b0;
        logic [15:0] snap_d = '0;
        logic [2:0]  snap_u = '0;
        logic [18:0] e;
        result_ready = (stall == 0);
        while (n_done == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            write = 1'b0;
            if (cyc == 3) sum_trigger = 1'b0;
            if (inject) begin
                if (cyc == 2) begin
                    write = 1'b1; unit_sel = 3'd3; unit_address = 3'd0; ram_data = 32'hDEAD_BEEF;
                end
                if (cyc == 4) sum_trigger = 1'b1;
                if (cyc == 5) sum_trigger = 1'b0;
            end
            if (done) begin
                n_done++;
                check("busy_at_done", 32'(busy), 32'h0);
                check("sb_empty_at_done", 32'(sb.size()), 32'h0);
            end
            if (prev_v && held) begin
                check("hold_valid", 32'(result_valid), 32'h1);
                check("hold_data", 32'(result_data), 32'(snap_d));
                check("hold_unit", 32'(result_unit), 32'(snap_u));
            end
            held = 1'b0;
            if (result_valid) begin
                if (!prev_v) begin
                    check("valid_latency", 32'(cyc), 32'(last_acc + LAT));
                    snap_d = result_data;
                    snap_u = result_unit;
                end
                if (stall_left > 0) begin
                    result_ready = 1'b0;
                    stall_left--;
                    held = 1'b1;
                end else begin
                    result_ready = 1'b1;
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'h1, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        check("result_unit", 32'(result_unit), 32'(e[18:16]));
                        check("result_data", 32'(result_data), 32'(e[15:0]));
                    end
                    last_acc = cyc;
                end
            end
            prev_v = result_valid;
        end
        if (n_done == 0) check("done_timeout", 32'h0, 32'h1);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'h0);
        check("valid_after_done", 32'(result_valid), 32'h0);
        check("unit_held_after_done", 32'(result_unit), 32'h3);
        sb.delete();
    endtask

    initial begin
        bit seen;
        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        // basic sum: unit 0 = 4 x (0x0100 * 0x0200) >>> 8 = 0x0800
        for (int i = 0; i < 4; i++) wr(3'd0, 3'(i), 16'h0100, 16'h0200);
        push4(16'h0800, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        sum_trigger = 1'b1;
        collect(0, 1'b0);
        check("overrun_basic", 32'(overrun), 32'h0);

        // backpressure on the first result
        push4(16'h0800, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        sum_trigger = 1'b1;
        collect(10, 1'b0);

        // saturation, negative product, out-of-range drops, write concurrent with start
        for (int i = 0; i < 4; i++) wr(3'd2, 3'(i), 16'h7FFF, 16'h7FFF);
        wr(3'd3, 3'd0, 16'hFF00, 16'h0300);
        wr(3'd5, 3'd1, 16'h1111, 16'h2222);
        wr(3'd0, 3'd6, 16'h3333, 16'h4444);
        push4(16'h0800, 16'h0001, BIG_EXP, 16'hFD00);
        @(negedge clk);
        write = 1'b1; unit_sel = 3'd1; unit_address = 3'd0; ram_data = {16'h0001, 16'h0100};
        sum_trigger = 1'b1;
        collect(0, 1'b0);
        check("overrun_idle_write", 32'(overrun), 32'h0);

        // write and second start edge while busy
        push4(16'h0800, 16'h0001, BIG_EXP, 16'hFD00);
        @(negedge clk);
        sum_trigger = 1'b1;
        collect(0, 1'b1);
        check("overrun_set", 32'(overrun), 32'h1);
        repeat (3) @(negedge clk);
        check("overrun_sticky", 32'(overrun), 32'h1);

        // reset during unit 1 MAC
        sum_trigger = 1'b1;
        result_ready = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 50 && !seen; c++) begin
            @(negedge clk);
            if (c == 3) sum_trigger = 1'b0;
            if (result_valid) seen = 1'b1;
        end
        sum_trigger = 1'b0;
        check("mid_first_result_seen", 32'(seen), 32'h1);
        repeat (2) @(negedge clk);
        check("mid_busy_before_reset", 32'(busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b1;
        push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        sum_trigger = 1'b1;
        collect(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
